// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RV32I execute unit with a valid/ready handshake.
//
// Decodes the main-decoder alu_op plus instruction funct fields into an ALU
// operation, executes it and holds the registered result until the consumer
// takes it. Single-cycle ops go IDLE -> DONE. With ALU_EXEC_MULDIV_EN defined,
// RV32M ops run an iterative shift-add multiply / restoring divide in BUSY.
// Without the macro, M encodings complete as illegal single-cycle ops.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready  operation handshake (in_ready high only in IDLE)
//   alu_op, opb5, funct3, funct7b5, funct7b0  decode fields
//   src_a, src_b         operands
//   out_valid / out_ready result handshake
//   result, zero, illegal registered outputs, stable while out_valid
module alu_exec_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic            opb5,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic            funct7b0,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam int unsigned ShW = $clog2(XLEN);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;

    logic [XLEN-1:0] alu_res;
    logic            is_m;
    logic            is_illegal;
    logic [ShW-1:0]  shamt;
    logic            accept;

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;
    assign accept    = in_valid & in_ready;
    assign shamt     = src_b[ShW-1:0];

    // Single-cycle ALU and decode, evaluated on the live inputs at accept.
    always_comb begin
        alu_res    = '0;
        is_m       = 1'b0;
        is_illegal = 1'b0;
        unique case (alu_op)
            2'b00: alu_res = src_a + src_b;
            2'b01: alu_res = src_a - src_b;
            2'b11: alu_res = src_b;
            2'b10: begin
                if (opb5 & funct7b0) begin
`ifdef ALU_EXEC_MULDIV_EN
                    is_m = 1'b1;
`else
                    is_illegal = 1'b1;
`endif
                end else begin
                    case (funct3)
                        3'b000: alu_res = (opb5 & funct7b5) ? src_a - src_b : src_a + src_b;
                        3'b001: alu_res = src_a << shamt;
                        3'b010: alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
                        3'b011: alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
                        3'b100: alu_res = src_a ^ src_b;
                        3'b101: alu_res = funct7b5 ? XLEN'($signed(src_a) >>> shamt)
                                                   : src_a >> shamt;
                        3'b110: alu_res = src_a | src_b;
                        3'b111: alu_res = src_a & src_b;
                    endcase
                end
            end
        endcase
    end

`ifdef ALU_EXEC_MULDIV_EN
    localparam int unsigned CntW = ShW + 1;

    logic [XLEN-1:0]   m_a_q, m_a_d;
    logic [XLEN-1:0]   m_b_q, m_b_d;
    logic [2:0]        m_f3_q, m_f3_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    // funct3[2] selects divide; otherwise the MUL* variant sets operand signedness.
    function automatic logic f3_a_signed(input logic [2:0] f3);
        return f3[2] ? ~f3[0] : (f3[1:0] != 2'b11);
    endfunction

    function automatic logic f3_b_signed(input logic [2:0] f3);
        return f3[2] ? ~f3[0] : ~f3[1];
    endfunction

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic s);
        return (s & v[XLEN-1]) ? -v : v;
    endfunction

    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_trial;
    logic [2*XLEN-1:0] mul_step, div_step;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;
    logic [XLEN-1:0]   m_res;

    always_comb begin
        a_neg = f3_a_signed(m_f3_q) & m_a_q[XLEN-1];
        b_neg = f3_b_signed(m_f3_q) & m_b_q[XLEN-1];
        a_mag = a_neg ? -m_a_q : m_a_q;
        b_mag = b_neg ? -m_b_q : m_b_q;

        // Multiply: acc = {partial, multiplier}; add on lsb, then shift right.
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_mag} : '0);
        mul_step = {mul_sum, acc_q[XLEN-1:1]};

        // Restoring divide: acc = {remainder, dividend/quotient}, shift left.
        div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_mag};
        if (!div_trial[XLEN]) begin
            div_step = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            div_step = {acc_q[2*XLEN-2:0], 1'b0};
        end

        prod = (a_neg ^ b_neg) ? -acc_q : acc_q;
        quo  = (a_neg ^ b_neg) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem  = a_neg ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        // Magnitude divide by zero already yields rem = |a|, which the sign fix
        // turns back into src_a; only the quotient needs forcing to all ones.
        if (m_b_q == '0) begin
            quo = '1;
        end

        if (m_f3_q[2]) begin
            m_res = m_f3_q[1] ? rem : quo;
        end else begin
            m_res = (m_f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
`ifdef ALU_EXEC_MULDIV_EN
        m_a_d  = m_a_q;
        m_b_d  = m_b_q;
        m_f3_d = m_f3_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
`ifdef ALU_EXEC_MULDIV_EN
                    if (is_m) begin
                        state_d = StBusy;
                        m_a_d   = src_a;
                        m_b_d   = src_b;
                        m_f3_d  = funct3;
                        cnt_d   = '0;
                        acc_d   = funct3[2]
                            ? {{XLEN{1'b0}}, mag(src_a, f3_a_signed(funct3))}
                            : {{XLEN{1'b0}}, mag(src_b, f3_b_signed(funct3))};
                    end else
`endif
                    begin
                        state_d   = StDone;
                        result_d  = is_illegal ? '0 : alu_res;
                        zero_d    = is_illegal ? 1'b1 : (alu_res == '0);
                        illegal_d = is_illegal;
                    end
                end
            end
            StBusy: begin
`ifdef ALU_EXEC_MULDIV_EN
                if (cnt_q == CntW'(XLEN)) begin
                    state_d   = StDone;
                    result_d  = m_res;
                    zero_d    = (m_res == '0);
                    illegal_d = 1'b0;
                end else begin
                    acc_d = m_f3_q[2] ? div_step : mul_step;
                    cnt_d = cnt_q + 1'b1;
                end
`else
                state_d = StIdle;
`endif
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
`ifdef ALU_EXEC_MULDIV_EN
            m_a_q  <= '0;
            m_b_q  <= '0;
            m_f3_q <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
`ifdef ALU_EXEC_MULDIV_EN
            m_a_q  <= m_a_d;
            m_b_q  <= m_b_d;
            m_f3_q <= m_f3_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
`endif
        end
    end

endmodule
